// File: rtl/float_accum_ctrl_pkg.sv
// rtl/float_accum_ctrl_pkg.sv - shared float encodings and accumulator state type
package float_accum_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT
    } state_e;

    function automatic int exp_width(input int fw);
        return (fw == 32) ? 8 : 11;
    endfunction

    function automatic int frac_width(input int fw);
        return fw - 1 - exp_width(fw);
    endfunction

    function automatic logic [63:0] zero_bits(input int fw, input logic neg);
        return neg ? (64'(1) << (fw - 1)) : 64'(0);
    endfunction

    function automatic logic [63:0] inf_bits(input int fw, input logic neg);
        return zero_bits(fw, neg) | (((64'(1) << exp_width(fw)) - 64'(1)) << frac_width(fw));
    endfunction

    function automatic logic [63:0] qnan_bits(input int fw);
        return inf_bits(fw, 1'b0) | (64'(1) << (frac_width(fw) - 1));
    endfunction

endpackage

// File: rtl/float_accum_ctrl_wait.sv
// rtl/float_accum_ctrl_wait.sv - adder done qualification and response timeout
module float_accum_ctrl_wait #(
    parameter int WAIT_LIMIT = 31
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic active_i,
    input  logic add_done_i,
    output logic complete_o,
    output logic timeout_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          low_seen_q, low_seen_d;

    // done is left high by the previous op; only a low-then-high sequence counts
    assign complete_o = active_i && low_seen_q && add_done_i;
    assign timeout_o  = active_i && !complete_o && (cnt_q == LAST);

    always_comb begin
        cnt_d      = cnt_q;
        low_seen_d = low_seen_q;
        if (clear_i) begin
            cnt_d      = '0;
            low_seen_d = 1'b0;
        end else if (active_i) begin
            if (!add_done_i) begin
                low_seen_d = 1'b1;
            end
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            low_seen_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            low_seen_q <= low_seen_d;
        end
    end

endmodule

// File: rtl/float_accum_ctrl.sv
// rtl/float_accum_ctrl.sv - sums a stream of floats by sequencing add_float start/done ops
module float_accum_ctrl
    import float_accum_ctrl_pkg::*;
#(
    parameter int FLOAT_WIDTH = 64,
    parameter int CNT_WIDTH   = 16,
    parameter int WAIT_LIMIT  = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [CNT_WIDTH-1:0]   cmd_len_i,
    input  logic                   cmd_sub_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [FLOAT_WIDTH-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [FLOAT_WIDTH-1:0] out_sum_o,
    output logic                   out_nan_o,
    output logic                   out_ovf_o,
    output logic                   out_unf_o,
    output logic                   out_timeout_o,
    output logic                   add_start_o,
    output logic                   add_op_sub_o,
    output logic [FLOAT_WIDTH-1:0] add_op1_o,
    output logic [FLOAT_WIDTH-1:0] add_op2_o,
    input  logic [FLOAT_WIDTH-1:0] add_out_i,
    input  logic                   add_nan_i,
    input  logic                   add_overflow_i,
    input  logic                   add_underflow_i,
    input  logic                   add_zero_i,
    input  logic                   add_done_i
);

    localparam logic [FLOAT_WIDTH-1:0] POS_ZERO = FLOAT_WIDTH'(zero_bits(FLOAT_WIDTH, 1'b0));
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic                   sub_q, sub_d;
    logic [FLOAT_WIDTH-1:0] acc_q, acc_d;
    logic [FLOAT_WIDTH-1:0] op1_q, op1_d;
    logic [FLOAT_WIDTH-1:0] op2_q, op2_d;
    logic                   nan_q, nan_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   to_q, to_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   add_start_q, add_start_d;

    logic cmd_fire, in_fire, last_term, op_complete, op_timeout;
    logic unused_zero;

    // zero results already carry the adder's sign, so the zero flag adds nothing
    assign unused_zero = add_zero_i;

    assign cmd_fire  = cmd_valid_i && cmd_ready_q;
    assign in_fire   = in_valid_i && in_ready_q;
    assign last_term = (rem_q == CNT_ONE);

    float_accum_ctrl_wait #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_q == ST_ISSUE),
        .active_i   (state_q == ST_WAIT),
        .add_done_i (add_done_i),
        .complete_o (op_complete),
        .timeout_o  (op_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_len_i == '0) ? ST_RESULT : ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (in_fire) begin
                    state_d = last_term ? ST_RESULT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (in_fire) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (op_complete) begin
                    state_d = last_term ? ST_RESULT : ST_FETCH;
                end else if (op_timeout) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // handshake outputs are decoded from the next state so they are pure flops
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        in_ready_d  = (state_d == ST_FIRST) || (state_d == ST_FETCH);
        out_valid_d = (state_d == ST_RESULT);
        add_start_d = (state_d == ST_ISSUE);
    end

    always_comb begin
        rem_d = rem_q;
        sub_d = sub_q;
        acc_d = acc_q;
        op1_d = op1_q;
        op2_d = op2_q;
        nan_d = nan_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        to_d  = to_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    rem_d = cmd_len_i;
                    sub_d = cmd_sub_i;
                    acc_d = POS_ZERO;
                    nan_d = 1'b0;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    to_d  = 1'b0;
                end
            end
            ST_FIRST: begin
                if (in_fire) begin
                    acc_d = in_data_i;
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_FETCH: begin
                if (in_fire) begin
                    op1_d = acc_q;
                    op2_d = in_data_i;
                end
            end
            ST_WAIT: begin
                if (op_complete) begin
                    acc_d = add_out_i;
                    nan_d = nan_q | add_nan_i;
                    ovf_d = ovf_q | add_overflow_i;
                    unf_d = unf_q | add_underflow_i;
                    rem_d = rem_q - 1'b1;
                end else if (op_timeout) begin
                    to_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            sub_q       <= 1'b0;
            acc_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            to_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            add_start_q <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            sub_q       <= sub_d;
            acc_q       <= acc_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            nan_q       <= nan_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            to_q        <= to_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            add_start_q <= add_start_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_sum_o     = acc_q;
    assign out_nan_o     = nan_q;
    assign out_ovf_o     = ovf_q;
    assign out_unf_o     = unf_q;
    assign out_timeout_o = to_q;
    assign add_start_o   = add_start_q;
    assign add_op_sub_o  = sub_q;
    assign add_op1_o     = op1_q;
    assign add_op2_o     = op2_q;

endmodule

// File: tb/tb_float_accum_ctrl.sv
// tb/tb_float_accum_ctrl.sv - randomized bench for float_accum_ctrl with a behavioural adder
module tb_float_accum_ctrl;

    localparam int FW = 32;
    localparam int CW = 16;
    localparam int WL = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [CW-1:0] cmd_len_i = '0;
    logic          cmd_sub_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [FW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [FW-1:0] out_sum_o;
    logic          out_nan_o, out_ovf_o, out_unf_o, out_timeout_o;
    logic          add_start_o, add_op_sub_o;
    logic [FW-1:0] add_op1_o, add_op2_o;
    logic [FW-1:0] add_out_i = '0;
    logic          add_nan_i = 1'b0, add_overflow_i = 1'b0, add_underflow_i = 1'b0;
    logic          add_zero_i = 1'b0, add_done_i = 1'b1;

    int checks = 0;
    int errors = 0;
    bit stub_hang = 1'b0;
    int last_lat = 0;
    logic [31:0] terms[$];

    always #5 clk = ~clk;

    float_accum_ctrl #(.FLOAT_WIDTH(FW), .CNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_len_i(cmd_len_i), .cmd_sub_i(cmd_sub_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_sum_o(out_sum_o),
        .out_nan_o(out_nan_o), .out_ovf_o(out_ovf_o), .out_unf_o(out_unf_o),
        .out_timeout_o(out_timeout_o),
        .add_start_o(add_start_o), .add_op_sub_o(add_op_sub_o),
        .add_op1_o(add_op1_o), .add_op2_o(add_op2_o), .add_out_i(add_out_i),
        .add_nan_i(add_nan_i), .add_overflow_i(add_overflow_i),
        .add_underflow_i(add_underflow_i), .add_zero_i(add_zero_i), .add_done_i(add_done_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] int_to_sp(input int v);
        int m;
        int e;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        e = 0;
        for (int i = 0; i < 24; i++) if (((m >> i) & 1) != 0) e = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(e + 127);
        r[22:0]  = 23'(m << (23 - e));
        return r;
    endfunction

    function automatic real sp_to_real(input logic [31:0] a);
        if (a[30:0] == 31'h0) return 0.0;
        return $bitstoreal({a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'h0});
    endfunction

    // {nan, ovf, result}; normals only, which is all this bench feeds it
    function automatic logic [33:0] stub_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real r;
        logic [63:0] d;
        int e;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return {1'b1, 1'b0, 32'h7FC00000};
        r = sub ? sp_to_real(a) - sp_to_real(b) : sp_to_real(a) + sp_to_real(b);
        if (r == 0.0) return {2'b00, 32'h0};
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {1'b0, 1'b1, d[63], 8'hFF, 23'h0};
        return {2'b00, d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] st_res;
    logic        st_nan, st_ovf;
    int          st_drop, st_lat;
    bit          st_busy = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            st_busy    <= 1'b0;
            add_done_i <= 1'b1;
        end else if (add_start_o) begin
            if (!stub_hang) begin
                {st_nan, st_ovf, st_res} <= stub_add(add_op1_o, add_op2_o, add_op_sub_o);
                st_drop <= $urandom_range(0, 2);
                st_lat  <= $urandom_range(1, 4);
                st_busy <= 1'b1;
            end
        end else if (st_busy) begin
            if (st_drop > 0) st_drop <= st_drop - 1;
            else if (add_done_i) add_done_i <= 1'b0;
            else if (st_lat > 1) st_lat <= st_lat - 1;
            else begin
                add_done_i     <= 1'b1;
                add_out_i      <= st_res;
                add_nan_i      <= st_nan;
                add_overflow_i <= st_ovf;
                st_busy        <= 1'b0;
            end
        end
    end

    task automatic run_cmd(input string tag, input int len, input bit sub, input int hold,
                           input logic [31:0] e_sum, input bit e_nan, input bit e_ovf,
                           input bit e_to, input int e_starts);
        int  idx = 0, starts = 0, cyc = 0, start_cyc = 0, inrdy = 0;
        bit  fire_cmd, fire_in = 1'b0, got = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_len_i   = CW'(len);
        cmd_sub_i   = sub;
        out_ready_i = 1'b0;
        fire_cmd    = cmd_ready_o;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (fire_cmd) begin
                cmd_valid_i = 1'b0;
                fire_cmd    = 1'b0;
            end else if (cmd_valid_i) begin
                fire_cmd = cmd_ready_o;
            end
            if (fire_in) idx++;
            if (add_start_o) begin
                starts++;
                start_cyc = cyc;
            end
            if (in_ready_o) inrdy++;
            in_valid_i = (idx < terms.size()) && ($urandom_range(0, 3) != 0);
            in_data_i  = (idx < terms.size()) ? terms[idx] : 32'($urandom);
            fire_in    = in_valid_i && in_ready_o;
            if (out_valid_o) got = 1'b1;
        end
        in_valid_i = 1'b0;
        last_lat = cyc - start_cyc;
        chk({tag, "_valid"}, 64'(got), 64'(1));
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_sum"}, {out_valid_o, in_ready_o, cmd_ready_o, out_sum_o},
                {1'b1, 1'b0, 1'b0, e_sum});
            @(negedge clk);
        end
        chk({tag, "_sum"}, out_sum_o, e_sum);
        chk({tag, "_flags"}, {out_nan_o, out_ovf_o, out_unf_o, out_timeout_o},
            {e_nan, e_ovf, 1'b0, e_to});
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk({tag, "_taken"}, {out_valid_o, cmd_ready_o}, 2'b01);
        chk({tag, "_starts"}, 64'(starts), 64'(e_starts));
        chk({tag, "_consumed"}, 64'(idx), 64'(e_to ? 2 : len));
        chk({tag, "_inrdy_seen"}, 64'(inrdy != 0), 64'(len != 0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs", {cmd_ready_o, in_ready_o, out_valid_o, add_start_o,
                            out_nan_o, out_ovf_o, out_unf_o, out_timeout_o}, 8'h00);
        chk("rst_sum", out_sum_o, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", cmd_ready_o, 1'b1);

        terms = '{32'h3F800000, 32'h40000000, 32'h40400000};
        run_cmd("sum3", 3, 1'b0, 0, 32'h40C00000, 0, 0, 0, 2);
        terms.delete();
        run_cmd("len0", 0, 1'b0, 2, 32'h00000000, 0, 0, 0, 0);
        terms = '{32'h3F800000};
        run_cmd("len1", 1, 1'b0, 1, 32'h3F800000, 0, 0, 0, 0);
        terms = '{32'h40400000, 32'h3F800000};
        run_cmd("sub2", 2, 1'b1, 0, 32'h40000000, 0, 0, 0, 1);
        terms = '{32'h3F800000, 32'h7FC00000};
        run_cmd("nan2", 2, 1'b0, 5, 32'h7FC00000, 1, 0, 0, 1);
        terms = '{32'h40000000, 32'h40400000, 32'h3F800000};
        run_cmd("after_nan", 3, 1'b0, 0, 32'h40C00000, 0, 0, 0, 2);
        terms = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        run_cmd("ovf2", 2, 1'b0, 1, 32'h7F800000, 0, 1, 0, 1);

        stub_hang = 1'b1;
        terms = '{32'h40400000, 32'h3F800000, 32'h40000000};
        run_cmd("tmo", 3, 1'b0, 2, 32'h40400000, 0, 0, 1, 1);
        chk("tmo_latency", 64'(last_lat), 64'(WL + 1));
        stub_hang = 1'b0;

        // reset in the middle of a command abandons it
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_len_i   = CW'(5);
        in_valid_i  = 1'b1;
        in_data_i   = 32'h3F800000;
        repeat (6) @(negedge clk);
        cmd_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {cmd_ready_o, in_ready_o, out_valid_o, add_start_o}, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle", {cmd_ready_o, out_valid_o}, 2'b10);
        terms = '{32'h40000000, 32'h40000000};
        run_cmd("post_abort", 2, 1'b0, 0, 32'h40800000, 0, 0, 0, 1);

        for (int n = 0; n < 12; n++) begin
            int len, s, v;
            bit sb;
            len = $urandom_range(0, 6);
            sb  = 1'($urandom_range(0, 1));
            s   = 0;
            terms.delete();
            for (int i = 0; i < len; i++) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                terms.push_back(int_to_sp(v));
                if (i == 0) s = v;
                else s = sb ? s - v : s + v;
            end
            run_cmd($sformatf("rnd%0d", n), len, sb, $urandom_range(0, 3), int_to_sp(s),
                    0, 0, 0, (len > 1) ? len - 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
